// File: rtl/perm_lane_tx.sv
// Pads a 64-bit message-word stream and emits 25-lane Keccak blocks: data, pad, then zero capacity lanes.
// One cycle from accepted word to dout; output register holds while pushout & stopout, and stopin rises during PAD/CAP or an output stall.
module perm_lane_tx #(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DSBYTE     = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    output logic        stopin,
    input  logic        firstin,
    input  logic        lastin,
    input  logic [3:0]  bytesin,
    input  logic [63:0] din,
    output logic        pushout,
    input  logic        stopout,
    output logic        firstout,
    output logic        lastout,
    output logic [63:0] dout,
    output logic        err
);
    localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0] LAST_LANE = 5'd24;

    typedef enum logic [1:0] {IDLE, DATA, PAD, CAP} state_t;

    state_t      state, state_nxt;
    logic [4:0]  lc, lc_nxt;
    logic        more, more_nxt;
    logic        pad_ds, pad_ds_nxt;
    logic        advance, accept, load, lane_last, err_set;
    logic        full_word;
    logic [3:0]  nb;
    logic [63:0] lane, word_pad;

    assign advance = ~pushout | ~stopout;
    assign stopin  = ~rst | (state == PAD) | (state == CAP) | (pushout & stopout);
    assign accept  = pushin & ~stopin;

    // A short final word carries its own DSBYTE; a full one defers it to the next lane.
    always_comb begin
        nb        = (bytesin > 4'd8) ? 4'd8 : bytesin;
        full_word = ~lastin | (nb == 4'd8);
        word_pad  = din;
        if (!full_word) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) > nb) begin
                    word_pad[8*k +: 8] = 8'h00;
                end else if (4'(k) == nb) begin
                    word_pad[8*k +: 8] = DSBYTE;
                end
            end
            if (lc == LAST_RATE) begin
                word_pad[63:56] = word_pad[63:56] ^ 8'h80;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        lc_nxt     = lc;
        more_nxt   = more;
        pad_ds_nxt = pad_ds;
        load       = 1'b0;
        lane       = '0;
        lane_last  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    load    = 1'b1;
                    lane    = word_pad;
                    lc_nxt  = lc + 5'd1;
                    err_set = (lastin & (bytesin > 4'd8)) | (firstin ^ (state == IDLE));
                    if (lc == LAST_RATE) begin
                        // Block closes here; a deferred DSBYTE needs one extra block.
                        state_nxt  = CAP;
                        more_nxt   = full_word;
                        pad_ds_nxt = lastin & full_word;
                    end else if (lastin) begin
                        state_nxt  = PAD;
                        pad_ds_nxt = full_word;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            PAD: begin
                if (advance) begin
                    load       = 1'b1;
                    lane       = {(lc == LAST_RATE) ? 8'h80 : 8'h00, 48'h0, pad_ds ? DSBYTE : 8'h00};
                    pad_ds_nxt = 1'b0;
                    lc_nxt     = lc + 5'd1;
                    if (lc == LAST_RATE) begin
                        state_nxt = CAP;
                        more_nxt  = 1'b0;
                    end
                end
            end
            CAP: begin
                if (advance) begin
                    load = 1'b1;
                    if (lc == LAST_LANE) begin
                        lc_nxt    = 5'd0;
                        lane_last = ~more;
                        more_nxt  = 1'b0;
                        state_nxt = !more ? IDLE : (pad_ds ? PAD : DATA);
                    end else begin
                        lc_nxt = lc + 5'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lc       <= 5'd0;
            more     <= 1'b0;
            pad_ds   <= 1'b0;
            pushout  <= 1'b0;
            firstout <= 1'b0;
            lastout  <= 1'b0;
            dout     <= 64'h0;
            err      <= 1'b0;
        end else begin
            state  <= state_nxt;
            lc     <= lc_nxt;
            more   <= more_nxt;
            pad_ds <= pad_ds_nxt;
            err    <= err | err_set;
            if (advance) begin
                pushout  <= load;
                dout     <= lane;
                firstout <= load & (lc == 5'd0);
                lastout  <= lane_last;
            end
        end
    end
endmodule
